// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA raster timing from free-running active-low
// hsync/vsync inputs. It synchronizes both syncs, regenerates pixel/line
// counters, measures line and frame length, and declares lock once
// LOCK_FRAMES consecutive consistent frames have been seen.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-low reset
//   hsync_in        active-low horizontal sync (asynchronous to clk)
//   vsync_in        active-low vertical sync (asynchronous to clk)
//   h_cnt, v_cnt    recovered pixel / line counters (saturate at 4095)
//   enable          active-video window (combinational, gated by locked)
//   locked          stable timing detected
//   line_period     measured clocks per line
//   frame_lines     measured lines per frame
//   sync_err        one-cycle pulse on loss of lock
//   err_cnt         loss-of-lock count
//
// Build option: define VGA_SYNC_RX_ERRCNT_EN to implement the saturating
// err_cnt register; otherwise err_cnt is tied to 0.
module vga_sync_receiver #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        enable,
    output logic        locked,
    output logic [11:0] line_period,
    output logic [11:0] frame_lines,
    output logic        sync_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CW = 12;
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] H_START  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_END    = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_START  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_END    = CW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [1:0]    hs_sync, vs_sync;
    logic          hs_hist, vs_hist;
    logic          hs_fall, vs_fall;
    logic [CW-1:0] cur_line, cur_frame;
    logic          h_lost, line_bad_c, good_frame, len_match, lock_loss, lock_ok;
    logic [GW-1:0] good_cnt, good_cnt_nx, cnt_inc;
    logic          frame_bad, frame_bad_nx;
    logic          need_line, need_line_nx;
    logic [CW-1:0] line_period_nx, frame_lines_nx;
    logic          sync_err_nx;

    // Two-flop synchronizers plus history flop; idle level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_sync <= 2'b11;
            vs_sync <= 2'b11;
            hs_hist <= 1'b1;
            vs_hist <= 1'b1;
        end else begin
            hs_sync <= {hs_sync[0], hsync_in};
            vs_sync <= {vs_sync[0], vsync_in};
            hs_hist <= hs_sync[1];
            vs_hist <= vs_sync[1];
        end
    end

    assign hs_fall = hs_hist & ~hs_sync[1];
    assign vs_fall = vs_hist & ~vs_sync[1];

    // Recovered raster counters; a frame restart wins over a line increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_fall)
                h_cnt <= '0;
            else if (h_cnt != CNT_MAX)
                h_cnt <= h_cnt + CW'(1);
            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall && v_cnt != CNT_MAX)
                v_cnt <= v_cnt + CW'(1);
        end
    end

    assign cur_line   = h_cnt + CW'(1);
    assign cur_frame  = v_cnt + CW'(1);
    assign h_lost     = (h_cnt == CNT_MAX);
    assign line_bad_c = hs_fall && !need_line && (cur_line != line_period);
    // A frame with no captured line is treated as bad
    assign good_frame = !(frame_bad || line_bad_c || need_line);
    assign len_match  = (cur_frame == frame_lines);
    assign cnt_inc    = good_cnt + GW'(1);
    assign lock_ok    = good_frame && len_match && (cnt_inc >= LOCK_TGT);
    assign lock_loss  = h_lost || (hs_fall && cur_line != line_period)
                               || (vs_fall && !len_match);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEARCH;
        else      state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            SEARCH:  if (vs_fall) state_nx = MEASURE;
            MEASURE: begin
                if (h_lost)                  state_nx = SEARCH;
                else if (vs_fall && lock_ok) state_nx = LOCKED;
            end
            LOCKED:  if (lock_loss) state_nx = SEARCH;
            default: state_nx = SEARCH;
        endcase
    end

    // FSM output / measurement next values
    always_comb begin
        good_cnt_nx    = good_cnt;
        frame_bad_nx   = frame_bad;
        need_line_nx   = need_line;
        line_period_nx = line_period;
        frame_lines_nx = frame_lines;
        sync_err_nx    = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    good_cnt_nx  = '0;
                    frame_bad_nx = 1'b0;
                    need_line_nx = 1'b1;
                end
            end
            MEASURE: begin
                if (hs_fall) begin
                    if (need_line) begin
                        line_period_nx = cur_line;
                        need_line_nx   = 1'b0;
                    end else if (cur_line != line_period) begin
                        frame_bad_nx = 1'b1;
                    end
                end
                if (vs_fall) begin
                    frame_bad_nx = 1'b0;
                    need_line_nx = 1'b1;
                    if (!good_frame) begin
                        good_cnt_nx = '0;
                    end else begin
                        frame_lines_nx = cur_frame;
                        // First good frame of a run has nothing to compare against
                        if (good_cnt != '0 && !len_match)
                            good_cnt_nx = '0;
                        else
                            good_cnt_nx = cnt_inc;
                    end
                end
            end
            LOCKED:  sync_err_nx = lock_loss;
            default: ;
        endcase
    end

    // Registered measurements and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_cnt    <= '0;
            frame_bad   <= 1'b0;
            need_line   <= 1'b0;
            line_period <= '0;
            frame_lines <= '0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            good_cnt    <= good_cnt_nx;
            frame_bad   <= frame_bad_nx;
            need_line   <= need_line_nx;
            line_period <= line_period_nx;
            frame_lines <= frame_lines_nx;
            sync_err    <= sync_err_nx;
            locked      <= (state_nx == LOCKED);
        end
    end

    assign enable = locked && (h_cnt >= H_START) && (h_cnt < H_END)
                           && (v_cnt >= V_START) && (v_cnt < V_END);

`ifdef VGA_SYNC_RX_ERRCNT_EN
    // Saturating loss-of-lock counter, advances together with the sync_err pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt <= '0;
        else if (sync_err_nx && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Testbench for vga_sync_receiver: randomized raster generator plus a
// position-based reference (counters trail the driven raster by 3 clocks).
module tb_vga_sync_receiver;

    localparam int unsigned H_SYNC      = 8;
    localparam int unsigned H_BP        = 6;
    localparam int unsigned H_ACTIVE    = 20;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BP        = 3;
    localparam int unsigned V_ACTIVE    = 10;
    localparam int unsigned LOCK_FRAMES = 2;
    localparam int LAT     = 3;
    localparam int SHORT_Y = 5;
    localparam int BUDGET  = 8000;
`ifdef VGA_SYNC_RX_ERRCNT_EN
    localparam int ERR_INC = 1;
`else
    localparam int ERR_INC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] h_cnt, v_cnt, line_period, frame_lines;
    logic        enable, locked, sync_err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    // generator state
    bit g_run = 0, g_hold = 0, g_alt = 0, g_short_arm = 0, g_short_hit = 0;
    int gx = 0, gy = 0, g_len = 40, g_frm = 20, g_cur_frm = 20;
    int g_frames = 0, g_last_frame = 0;

    vga_sync_receiver #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .locked(locked),
        .line_period(line_period), .frame_lines(frame_lines),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Raster generator: advance one pixel per clock, drive syncs 1 ns after the edge
    initial begin : gen
        int ll;
        forever begin
            @(posedge clk);
            #1;
            if (g_run) begin
                ll = (g_short_arm && gy == SHORT_Y) ? g_len - 1 : g_len;
                if (gx >= ll - 1) begin
                    if (g_short_arm && gy == SHORT_Y) begin
                        g_short_arm = 0;
                        g_short_hit = 1;
                    end
                    gx = 0;
                    if (gy >= g_cur_frm - 1) begin
                        gy = 0;
                        g_last_frame = g_cur_frm;
                        g_frames++;
                        if (g_alt) g_cur_frm = (g_cur_frm == g_frm) ? g_frm + 1 : g_frm;
                    end else begin
                        gy++;
                    end
                end else begin
                    gx++;
                end
                hsync_in = g_hold ? 1'b1 : (gx < H_SYNC ? 1'b0 : 1'b1);
                vsync_in = g_hold ? 1'b1 : (gy < V_SYNC ? 1'b0 : 1'b1);
            end else begin
                hsync_in = 1'b1;
                vsync_in = 1'b1;
            end
        end
    end

    task automatic start_gen(input bit alt);
        g_run       = 0;
        g_len       = $urandom_range(H_SYNC + H_BP + H_ACTIVE + 14, H_SYNC + H_BP + H_ACTIVE + 2);
        g_frm       = $urandom_range(V_SYNC + V_BP + V_ACTIVE + 8, V_SYNC + V_BP + V_ACTIVE + 2);
        g_cur_frm   = g_frm;
        g_alt       = alt;
        gx          = $urandom_range(g_len - 2, 0);
        gy          = $urandom_range(g_frm - 2, V_SYNC);
        g_frames    = 0;
        g_hold      = 0;
        g_short_arm = 0;
        g_short_hit = 0;
        g_run       = 1;
    endtask

    // Returns at the first falling edge after frame n has started
    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (g_frames >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_locked(output bit ok);
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (locked === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        tests++;
        if ({h_cnt, v_cnt, line_period, frame_lines} !== 48'd0) begin
            fails++;
            $display("FAIL reset_counters: h=%0d v=%0d lp=%0d fl=%0d, required all 0",
                     h_cnt, v_cnt, line_period, frame_lines);
        end
        tests++;
        if ({enable, locked, sync_err} !== 3'b000 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_flags: en=%b lk=%b se=%b ec=%0d, required 0",
                     enable, locked, sync_err, err_cnt);
        end
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic test_lock();
        bit ok;
        start_gen(0);
        wait_frames(2, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL lock_wait2: timeout, required frame 2"); end
        repeat (3) @(negedge clk);
        tests++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_early2: locked=%b, required 0", locked); end
        wait_frames(3, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL lock_wait3: timeout, required frame 3"); end
        repeat (2) @(negedge clk);
        tests++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_early3: locked=%b, required 0", locked); end
        @(negedge clk);
        tests++;
        if (locked !== 1'b1) begin fails++; $display("FAIL lock_3rd_vs: locked=%b, required 1", locked); end
        tests++;
        if (line_period !== 12'(g_len) || frame_lines !== 12'(g_frm)) begin
            fails++;
            $display("FAIL lock_measure: lp=%0d fl=%0d, required lp=%0d fl=%0d",
                     line_period, frame_lines, g_len, g_frm);
        end
    endtask

    task automatic test_window();
        bit ok;
        int p, ex, ey, bad, n_en, fh, fv, lh, lv;
        bit en_exp;
        bad = 0; n_en = 0; fh = -1; fv = -1; lh = -1; lv = -1;
        wait_frames(4, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL win_wait: timeout, required frame 4"); end
        for (int i = 0; i < g_len * g_frm; i++) begin
            @(negedge clk);
            p = gy * g_len + gx - LAT;
            if (p < 0) p += g_len * g_frm;
            ex = p % g_len;
            ey = p / g_len;
            en_exp = (ex >= H_SYNC + H_BP) && (ex < H_SYNC + H_BP + H_ACTIVE) &&
                     (ey >= V_SYNC + V_BP) && (ey < V_SYNC + V_BP + V_ACTIVE);
            if (h_cnt !== 12'(ex) || v_cnt !== 12'(ey) || enable !== en_exp || locked !== 1'b1)
                bad++;
            if (enable === 1'b1) begin
                if (n_en == 0) begin fh = h_cnt; fv = v_cnt; end
                lh = h_cnt; lv = v_cnt;
                n_en++;
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL win_model: %0d cycles disagree, required 0", bad); end
        tests++;
        if (fh != H_SYNC + H_BP || fv != V_SYNC + V_BP) begin
            fails++;
            $display("FAIL win_first: h=%0d v=%0d, required h=%0d v=%0d", fh, fv, H_SYNC + H_BP, V_SYNC + V_BP);
        end
        tests++;
        if (lh != H_SYNC + H_BP + H_ACTIVE - 1 || lv != V_SYNC + V_BP + V_ACTIVE - 1) begin
            fails++;
            $display("FAIL win_last: h=%0d v=%0d, required h=%0d v=%0d", lh, lv,
                     H_SYNC + H_BP + H_ACTIVE - 1, V_SYNC + V_BP + V_ACTIVE - 1);
        end
        tests++;
        if (n_en != H_ACTIVE * V_ACTIVE) begin
            fails++;
            $display("FAIL win_count: %0d enable cycles, required %0d", n_en, H_ACTIVE * V_ACTIVE);
        end
    endtask

    task automatic test_short_line();
        bit ok;
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (gy == 0) begin ok = 1; break; end
        end
        g_short_hit = 0;
        g_short_arm = 1;
        for (int i = 0; i < BUDGET && ok; i++) begin
            if (g_short_hit) break;
            @(negedge clk);
        end
        tests++;
        if (!ok || !g_short_hit) begin fails++; $display("FAIL short_wait: timeout, required short line"); end
        repeat (2) @(negedge clk);
        tests++;
        if (sync_err !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL short_before: se=%b lk=%b, required se=0 lk=1", sync_err, locked);
        end
        @(negedge clk);
        tests++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL short_pulse: se=%b lk=%b, required se=1 lk=0", sync_err, locked);
        end
        tests++;
        if (err_cnt !== 8'(ERR_INC)) begin
            fails++;
            $display("FAIL short_errcnt: err_cnt=%0d, required %0d", err_cnt, ERR_INC);
        end
        @(negedge clk);
        tests++;
        if (sync_err !== 1'b0) begin fails++; $display("FAIL short_width: se=%b, required 0", sync_err); end
    endtask

    task automatic test_hsync_hold();
        bit ok;
        wait_locked(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL hold_relock: timeout, required locked"); end
        repeat ($urandom_range(g_len, 1)) @(negedge clk);
        g_hold = 1;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (h_cnt === 12'hFFF) begin ok = 1; break; end
        end
        tests++;
        if (!ok || sync_err !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL hold_reach: reached=%b se=%b lk=%b, required 1 0 1", ok, sync_err, locked);
        end
        @(negedge clk);
        tests++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || h_cnt !== 12'hFFF) begin
            fails++;
            $display("FAIL hold_pulse: se=%b lk=%b h=%0d, required se=1 lk=0 h=4095", sync_err, locked, h_cnt);
        end
        tests++;
        if (err_cnt !== 8'(2 * ERR_INC)) begin
            fails++;
            $display("FAIL hold_errcnt: err_cnt=%0d, required %0d", err_cnt, 2 * ERR_INC);
        end
        @(negedge clk);
        tests++;
        if (sync_err !== 1'b0 || h_cnt !== 12'hFFF) begin
            fails++;
            $display("FAIL hold_after: se=%b h=%0d, required se=0 h=4095", sync_err, h_cnt);
        end
        g_hold = 0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int base;
        wait_locked(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rstm_relock: timeout, required locked"); end
        repeat ($urandom_range(g_len * g_frm / 2, 1)) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({h_cnt, v_cnt, line_period, frame_lines} !== 48'd0 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rstm_counters: h=%0d v=%0d lp=%0d fl=%0d ec=%0d, required 0",
                     h_cnt, v_cnt, line_period, frame_lines, err_cnt);
        end
        tests++;
        if ({enable, locked, sync_err} !== 3'b000) begin
            fails++;
            $display("FAIL rstm_flags: en=%b lk=%b se=%b, required 0", enable, locked, sync_err);
        end
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (i > 3 && gy >= V_SYNC && gy < g_cur_frm - 1) begin ok = 1; break; end
        end
        rst = 1'b1;
        base = g_frames;
        wait_frames(base + 2, ok);
        repeat (3) @(negedge clk);
        tests++;
        if (!ok || locked !== 1'b0) begin
            fails++;
            $display("FAIL rstm_early: ok=%b locked=%b, required ok=1 locked=0", ok, locked);
        end
        wait_frames(base + 3, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (!ok || locked !== 1'b0) begin
            fails++;
            $display("FAIL rstm_n2: ok=%b locked=%b, required ok=1 locked=0", ok, locked);
        end
        @(negedge clk);
        tests++;
        if (locked !== 1'b1) begin fails++; $display("FAIL rstm_relock3: locked=%b, required 1", locked); end
    endtask

    task automatic test_alternating();
        bit saw_lock;
        bit ok;
        saw_lock = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        start_gen(1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 2; k <= 7; k++) begin
            ok = 0;
            for (int i = 0; i < BUDGET; i++) begin
                @(negedge clk);
                if (locked !== 1'b0) saw_lock = 1;
                if (g_frames >= k) begin ok = 1; break; end
            end
            repeat (3) begin
                @(negedge clk);
                if (locked !== 1'b0) saw_lock = 1;
            end
            tests++;
            if (!ok || frame_lines !== 12'(g_last_frame)) begin
                fails++;
                $display("FAIL alt_frame_lines[%0d]: ok=%b fl=%0d, required %0d", k, ok, frame_lines, g_last_frame);
            end
        end
        tests++;
        if (saw_lock) begin fails++; $display("FAIL alt_never_lock: locked seen=1, required 0"); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_window();
        test_short_line();
        test_hsync_hold();
        test_reset_mid_frame();
        test_alternating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
